// File: rtl/frame_monitor_pkg.sv
// Shared types and error-bit indices for the frame protocol monitor.
package frame_monitor_pkg;

  localparam int ERR_W               = 6;
  localparam int ERR_EOP_NO_SOP      = 0;
  localparam int ERR_DOUBLE_SOP      = 1;
  localparam int ERR_MARKER_NO_VALID = 2;
  localparam int ERR_TOO_LONG        = 3;
  localparam int ERR_TOO_SHORT       = 4;
  localparam int ERR_SINGLE_BEAT     = 5;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/frame_protocol_monitor_if.sv
// Per-channel valid/SOP/EOP tap bundle shared by the source and the monitor.
interface frame_protocol_monitor_if #(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0] validIn;
  logic [NUM_CH-1:0] sopIn;
  logic [NUM_CH-1:0] eopIn;

  modport master (output validIn, sopIn, eopIn);
  modport slave  (input  validIn, sopIn, eopIn);
endinterface

// File: rtl/frame_monitor_channel.sv
// One channel of the frame protocol monitor: FSM, length tracking, error
// pulse/sticky registers and a wrapping completed-frame counter.
//   state    | meaning
//   IDLE     | waiting for a valid SOP beat
//   IN_FRAME | SOP seen, counting beats until EOP
module frame_monitor_channel
  import frame_monitor_pkg::*;
#(
  parameter int MIN_LEN           = 2,
  parameter int MAX_LEN           = 16,
  parameter int CNT_W             = 16,
  parameter int ALLOW_SINGLE_BEAT = 0
) (
  input  logic             i_clk,
  input  logic             i_srst,
  input  logic             i_valid,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             i_clearErr,
  output logic             o_inFrame,
  output logic [ERR_W-1:0] o_errPulse,
  output logic [ERR_W-1:0] o_errSticky,
  output logic [CNT_W-1:0] o_frameCount
);

  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [ERR_W-1:0] r_pulse;
  logic [ERR_W-1:0] r_sticky;
  logic [CNT_W-1:0] r_count;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_len_nxt;
  logic [ERR_W-1:0] w_pulse_nxt;
  logic             w_count_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_pulse_nxt = '0;
    w_count_inc = 1'b0;
    if (!i_valid) begin
      w_pulse_nxt[ERR_MARKER_NO_VALID] = i_sop | i_eop;
    end else if (r_state == IN_FRAME && !i_sop) begin
      if (i_eop) begin
        w_state_nxt = IDLE;
        w_len_nxt   = '0;
        w_count_inc = 1'b1;
        w_pulse_nxt[ERR_TOO_SHORT] = (int'(r_len) + 1 < MIN_LEN);
        // len==SAT means TOO_LONG was already flagged on an earlier beat
        w_pulse_nxt[ERR_TOO_LONG]  = (r_len == LEN_MAX);
      end else if (r_len != LEN_SAT) begin
        w_len_nxt = r_len + 1'b1;
        w_pulse_nxt[ERR_TOO_LONG] = (r_len == LEN_MAX);
      end
    end else begin
      // IDLE beat, or an SOP that abandons the open frame and restarts here
      w_pulse_nxt[ERR_DOUBLE_SOP] = (r_state == IN_FRAME);
      w_state_nxt = IDLE;
      w_len_nxt   = '0;
      case ({i_sop, i_eop})
        2'b10: begin
          w_state_nxt = IN_FRAME;
          w_len_nxt   = LEN_W'(1);
        end
        2'b01: w_pulse_nxt[ERR_EOP_NO_SOP] = 1'b1;
        2'b11: begin
          if (ALLOW_SINGLE_BEAT != 0) begin
            w_count_inc = 1'b1;
            w_pulse_nxt[ERR_TOO_SHORT] = (MIN_LEN > 1);
          end else begin
            w_pulse_nxt[ERR_SINGLE_BEAT] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_pulse  <= '0;
      r_sticky <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_pulse  <= w_pulse_nxt;
      r_sticky <= (r_sticky & ~{ERR_W{i_clearErr}}) | w_pulse_nxt;
      r_count  <= r_count + CNT_W'(w_count_inc);
    end
  end

  assign o_inFrame    = (r_state == IN_FRAME);
  assign o_errPulse   = r_pulse;
  assign o_errSticky  = r_sticky;
  assign o_frameCount = r_count;

endmodule

// File: rtl/frame_protocol_monitor.sv
// Multi-channel passive checker for the valid/SOP/EOP frame protocol.
module frame_protocol_monitor
  import frame_monitor_pkg::*;
#(
  parameter int NUM_CH            = 4,
  parameter int MIN_LEN           = 2,
  parameter int MAX_LEN           = 16,
  parameter int CNT_W             = 16,
  parameter int ALLOW_SINGLE_BEAT = 0
) (
  input  logic                    i_clk,
  input  logic                    i_srst,
  frame_protocol_monitor_if.slave tap,
  input  logic                    i_clearErr,
  output logic [NUM_CH-1:0]       o_inFrame,
  output logic [NUM_CH*ERR_W-1:0] o_errPulse,
  output logic [NUM_CH*ERR_W-1:0] o_errSticky,
  output logic                    o_anyErr,
  output logic [NUM_CH*CNT_W-1:0] o_frameCount
);

  generate
    if (MIN_LEN < 1 || MAX_LEN < MIN_LEN) begin : g_bad_len
      $error("frame_protocol_monitor: need 1 <= MIN_LEN <= MAX_LEN");
    end
  endgenerate

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    frame_monitor_channel #(
      .MIN_LEN          (MIN_LEN),
      .MAX_LEN          (MAX_LEN),
      .CNT_W            (CNT_W),
      .ALLOW_SINGLE_BEAT(ALLOW_SINGLE_BEAT)
    ) u_ch (
      .i_clk       (i_clk),
      .i_srst      (i_srst),
      .i_valid     (tap.validIn[c]),
      .i_sop       (tap.sopIn[c]),
      .i_eop       (tap.eopIn[c]),
      .i_clearErr  (i_clearErr),
      .o_inFrame   (o_inFrame[c]),
      .o_errPulse  (o_errPulse[c*ERR_W +: ERR_W]),
      .o_errSticky (o_errSticky[c*ERR_W +: ERR_W]),
      .o_frameCount(o_frameCount[c*CNT_W +: CNT_W])
    );
  end

  assign o_anyErr = |o_errSticky;

endmodule

// File: tb/tb_frame_protocol_monitor.sv
// Self-checking bench: directed vector table, hand sequences and random
// stimulus against a beat-level reference model, on two configurations.
module tb_frame_protocol_monitor;
  import frame_monitor_pkg::*;

  localparam int NCH  = 4;
  localparam int MINL = 2;
  localparam int MAXL = 16;
  localparam int CWA  = 16;
  localparam int CWB  = 2;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  frame_protocol_monitor_if #(.NUM_CH(NCH)) tap ();

  logic [NCH-1:0]     a_inf, b_inf;
  logic [NCH*6-1:0]   a_pulse, a_sticky, b_pulse, b_sticky;
  logic               a_any, b_any;
  logic [NCH*CWA-1:0] a_cnt;
  logic [NCH*CWB-1:0] b_cnt;

  frame_protocol_monitor #(.NUM_CH(NCH), .MIN_LEN(MINL), .MAX_LEN(MAXL),
                           .CNT_W(CWA), .ALLOW_SINGLE_BEAT(0)) dut_a (
    .i_clk(clk), .i_srst(srst), .tap(tap), .i_clearErr(clr),
    .o_inFrame(a_inf), .o_errPulse(a_pulse), .o_errSticky(a_sticky),
    .o_anyErr(a_any), .o_frameCount(a_cnt));

  frame_protocol_monitor #(.NUM_CH(NCH), .MIN_LEN(MINL), .MAX_LEN(MAXL),
                           .CNT_W(CWB), .ALLOW_SINGLE_BEAT(1)) dut_b (
    .i_clk(clk), .i_srst(srst), .tap(tap), .i_clearErr(clr),
    .o_inFrame(b_inf), .o_errPulse(b_pulse), .o_errSticky(b_sticky),
    .o_anyErr(b_any), .o_frameCount(b_cnt));

  typedef struct {
    bit         inf;
    int         len;
    bit         long_done;
    logic [5:0] pulse;
    logic [5:0] sticky;
    int         cnt;
  } ch_m_t;

  ch_m_t ma[NCH];
  ch_m_t mb[NCH];
  int checks = 0;
  int errors = 0;

  // Reference: beats counted as plain integers, frame rules applied directly.
  function automatic ch_m_t model_step(ch_m_t m_in, bit rst, bit v, bit s,
                                       bit e, bit c, bit allow);
    ch_m_t m = m_in;
    logic [5:0] p = '0;
    if (rst) begin
      m.inf = 0; m.len = 0; m.long_done = 0;
      m.pulse = '0; m.sticky = '0; m.cnt = 0;
      return m;
    end
    if (!v) begin
      if (s || e) p[2] = 1'b1;
    end else begin
      if (m.inf && s) begin
        p[1] = 1'b1;
        m.inf = 0;
      end
      if (m.inf) begin
        m.len = m.len + 1;
        if (e) begin
          if (m.len < MINL) p[4] = 1'b1;
          if (m.len > MAXL && !m.long_done) p[3] = 1'b1;
          m.cnt = m.cnt + 1;
          m.inf = 0;
        end else if (m.len == MAXL + 1 && !m.long_done) begin
          p[3] = 1'b1;
          m.long_done = 1;
        end
      end else begin
        if (s && !e) begin
          m.inf = 1; m.len = 1; m.long_done = 0;
        end else if (s && e) begin
          if (allow) begin
            m.cnt = m.cnt + 1;
            if (MINL > 1) p[4] = 1'b1;
          end else begin
            p[5] = 1'b1;
          end
        end else if (e) begin
          p[0] = 1'b1;
        end
      end
    end
    m.pulse  = p;
    m.sticky = (m.sticky & ~{6{c}}) | p;
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic compare_models();
    logic [NCH-1:0]     ei_a, ei_b;
    logic [NCH*6-1:0]   ep_a, es_a, ep_b, es_b;
    logic [NCH*CWA-1:0] ec_a;
    logic [NCH*CWB-1:0] ec_b;
    for (int c = 0; c < NCH; c++) begin
      ei_a[c] = ma[c].inf;           ei_b[c] = mb[c].inf;
      ep_a[c*6 +: 6] = ma[c].pulse;  es_a[c*6 +: 6] = ma[c].sticky;
      ep_b[c*6 +: 6] = mb[c].pulse;  es_b[c*6 +: 6] = mb[c].sticky;
      ec_a[c*CWA +: CWA] = CWA'(ma[c].cnt);
      ec_b[c*CWB +: CWB] = CWB'(mb[c].cnt);
    end
    chk("a_inFrame", 64'(a_inf), 64'(ei_a));
    chk("a_errPulse", 64'(a_pulse), 64'(ep_a));
    chk("a_errSticky", 64'(a_sticky), 64'(es_a));
    chk("a_anyErr", 64'(a_any), 64'(|es_a));
    chk("a_frameCount", a_cnt, ec_a);
    chk("b_inFrame", 64'(b_inf), 64'(ei_b));
    chk("b_errPulse", 64'(b_pulse), 64'(ep_b));
    chk("b_errSticky", 64'(b_sticky), 64'(es_b));
    chk("b_anyErr", 64'(b_any), 64'(|es_b));
    chk("b_frameCount", 64'(b_cnt), 64'(ec_b));
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] s,
                      input logic [3:0] e, input logic c, input logic r);
    @(negedge clk);
    tap.validIn = v; tap.sopIn = s; tap.eopIn = e; clr = c; srst = r;
    for (int ch = 0; ch < NCH; ch++) begin
      ma[ch] = model_step(ma[ch], r, v[ch], s[ch], e[ch], c, 1'b0);
      mb[ch] = model_step(mb[ch], r, v[ch], s[ch], e[ch], c, 1'b1);
    end
    @(posedge clk);
    #1;
    compare_models();
  endtask

  typedef struct {
    logic [3:0]  v, s, e;
    logic        c;
    logic [3:0]  inf;
    logic [23:0] pulse;
    logic        any;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tap.validIn = '0; tap.sopIn = '0; tap.eopIn = '0;
    //            v      s      e      c     inf    pulse       any
    tbl[0]  = '{4'h1, 4'h1, 4'h0, 1'b0, 4'h1, 24'h000000, 1'b0};
    tbl[1]  = '{4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 24'h000000, 1'b0};
    tbl[2]  = '{4'h1, 4'h0, 4'h0, 1'b0, 4'h1, 24'h000000, 1'b0};
    tbl[3]  = '{4'h1, 4'h0, 4'h1, 1'b0, 4'h0, 24'h000000, 1'b0};
    tbl[4]  = '{4'h2, 4'h0, 4'h2, 1'b0, 4'h0, 24'h000040, 1'b1};
    tbl[5]  = '{4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 24'h000000, 1'b1};
    tbl[6]  = '{4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 24'h000000, 1'b0};
    tbl[7]  = '{4'h4, 4'h4, 4'h0, 1'b0, 4'h4, 24'h000000, 1'b0};
    tbl[8]  = '{4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 24'h000000, 1'b0};
    tbl[9]  = '{4'h4, 4'h0, 4'h0, 1'b0, 4'h4, 24'h000000, 1'b0};
    tbl[10] = '{4'h4, 4'h4, 4'h0, 1'b0, 4'h4, 24'h002000, 1'b1};
    tbl[11] = '{4'h4, 4'h0, 4'h4, 1'b0, 4'h0, 24'h000000, 1'b1};
    tbl[12] = '{4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 24'h000000, 1'b0};
    tbl[13] = '{4'h0, 4'h1, 4'h0, 1'b0, 4'h0, 24'h000004, 1'b1};
    tbl[14] = '{4'h0, 4'h1, 4'h0, 1'b1, 4'h0, 24'h000004, 1'b1};
    tbl[15] = '{4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 24'h000000, 1'b0};
    tbl[16] = '{4'h8, 4'h8, 4'h0, 1'b0, 4'h8, 24'h000000, 1'b0};

    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("reset_frameCount", a_cnt, 64'h0);
    chk("reset_anyErr", 64'(a_any), 64'h0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].c, 1'b0);
      chk($sformatf("tbl%0d_inFrame", i), 64'(a_inf), 64'(tbl[i].inf));
      chk($sformatf("tbl%0d_errPulse", i), 64'(a_pulse), 64'(tbl[i].pulse));
      chk($sformatf("tbl%0d_anyErr", i), 64'(a_any), 64'(tbl[i].any));
    end
    chk("ch0_count_after_frame", 64'(a_cnt[15:0]), 64'd1);
    chk("ch2_count_after_double_sop", 64'(a_cnt[47:32]), 64'd1);

    // ch3 opened by tbl[16]; frame beats 2..18 carry no EOP
    for (int k = 2; k <= 18; k++) begin
      step(4'h8, 4'h0, 4'h0, 1'b0, 1'b0);
      chk($sformatf("too_long_beat%0d", k), 64'(a_pulse[21]), 64'(k == 17));
    end
    step(4'h8, 4'h0, 4'h8, 1'b0, 1'b0);
    chk("long_eop_pulse", 64'(a_pulse), 64'h0);
    chk("ch3_count_long", 64'(a_cnt[63:48]), 64'd1);

    step(4'h8, 4'h8, 4'h8, 1'b0, 1'b0);
    chk("single_beat_pulse_a", 64'(a_pulse), 64'h800000);
    chk("single_beat_count_a", 64'(a_cnt[63:48]), 64'd1);
    chk("single_beat_pulse_b", 64'(b_pulse), 64'h400000);

    step(4'h2, 4'h2, 4'h0, 1'b0, 1'b0);
    step(4'h2, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h2, 4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h2, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("srst_inFrame", 64'(a_inf), 64'h0);
    chk("srst_sticky", 64'(a_sticky), 64'h0);
    chk("srst_count", a_cnt, 64'h0);
    step(4'h2, 4'h0, 4'h2, 1'b0, 1'b0);
    chk("post_srst_eop_no_sop", 64'(a_pulse), 64'h000040);

    step(4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      step(4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
      step(4'h1, 4'h0, 4'h1, 1'b0, 1'b0);
    end
    chk("wrap_count_b", 64'(b_cnt[1:0]), 64'd1);
    chk("nowrap_count_a", 64'(a_cnt[15:0]), 64'd5);

    for (int n = 0; n < 3000; n++) begin
      logic [3:0] v, s, e;
      for (int c = 0; c < NCH; c++) begin
        v[c] = ($urandom_range(0, 3) != 0);
        s[c] = ($urandom_range(0, 9) == 0);
        e[c] = ($urandom_range(0, 11) == 0);
      end
      step(v, s, e, $urandom_range(0, 49) == 0, $urandom_range(0, 499) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
